windowed_register_file: RTL and testbench

- Parametrised SPARC-style windowed register file for the next-generation processor core; replaces the flat 32-entry file.
- Provides 8 globals plus NWINDOWS overlapping 24-register windows and two combinational read ports, one synchronous write port, and CWP/WIM management.
- Handles SAVE/RESTORE and raises registered window overflow/underflow trap pulses.

---
 rtl/windowed_register_file.sv | 109 ++++++++++
 tb/tb_windowed_register_file.sv | 131 +++++++++++++
 2 files changed

// File: rtl/windowed_register_file.sv
// SPARC-style windowed register file: 8 globals plus NWINDOWS overlapping 24-register windows,
// two combinational read ports, one write port, and CWP/WIM management with SAVE/RESTORE traps.
module windowed_register_file #(
    parameter int DATA_W   = 32,
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = $clog2(NWINDOWS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [4:0]          rd,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd1_data,
    output logic [DATA_W-1:0]   rd2_data,
    input  logic                save,
    input  logic                restore,
    input  logic                cwp_wr,
    input  logic [CWP_W-1:0]    cwp_in,
    input  logic                wim_wr,
    input  logic [NWINDOWS-1:0] wim_in,
    output logic [CWP_W-1:0]    cwp,
    output logic [NWINDOWS-1:0] wim,
    output logic                trap_ovf,
    output logic                trap_unf
);
    localparam int PHYS_W = CWP_W + 4;
    localparam int NPHYS  = NWINDOWS * 16;
    localparam logic [NWINDOWS-1:0] WIM_RST = NWINDOWS'(1) << (1 % NWINDOWS);

    logic [DATA_W-1:0] globals [8];
    logic [DATA_W-1:0] windows [NPHYS];

    logic [CWP_W-1:0] save_t, restore_t, cwp_next, wr_cwp;
    logic             ovf_next, unf_next, wr_ok;

    // NPHYS is a power of two, so truncation to PHYS_W bits is the modulo wrap.
    function automatic logic [PHYS_W-1:0] phys_idx(input logic [CWP_W-1:0] w, input logic [4:0] r);
        return {w, 4'b0000} + PHYS_W'(r - 5'd8);
    endfunction

    function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] r);
        if (r == 5'd0)
            return '0;
        else if (r[4:3] == 2'b00)
            return globals[r[2:0]];
        else
            return windows[phys_idx(cwp, r)];
    endfunction

    always_comb begin
        rd1_data = read_reg(rs1);
        rd2_data = read_reg(rs2);
    end

    assign save_t    = cwp - CWP_W'(1);
    assign restore_t = cwp + CWP_W'(1);

    // A trapping SAVE/RESTORE also kills the write; an accepted one writes in the new window.
    always_comb begin
        cwp_next = cwp;
        wr_cwp   = cwp;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        wr_ok    = wr_en && (rd != 5'd0);
        if (cwp_wr) begin
            cwp_next = cwp_in;
        end else if (save && !restore) begin
            if (wim[save_t]) begin
                ovf_next = 1'b1;
                wr_ok    = 1'b0;
            end else begin
                cwp_next = save_t;
                wr_cwp   = save_t;
            end
        end else if (restore && !save) begin
            if (wim[restore_t]) begin
                unf_next = 1'b1;
                wr_ok    = 1'b0;
            end else begin
                cwp_next = restore_t;
                wr_cwp   = restore_t;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cwp      <= '0;
            wim      <= WIM_RST;
            trap_ovf <= 1'b0;
            trap_unf <= 1'b0;
            for (int i = 0; i < 8; i++) globals[i] <= '0;
            for (int i = 0; i < NPHYS; i++) windows[i] <= '0;
        end else begin
            cwp      <= cwp_next;
            trap_ovf <= ovf_next;
            trap_unf <= unf_next;
            if (wim_wr) wim <= wim_in;
            if (wr_ok) begin
                if (rd[4:3] == 2'b00)
                    globals[rd[2:0]] <= wr_data;
                else
                    windows[phys_idx(wr_cwp, rd)] <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_windowed_register_file.sv
// Table-driven bench for windowed_register_file (NWINDOWS=4): reads checked before each edge,
// post-edge cwp/wim/trap expectations queued at drive time and popped after the edge.
module tb_windowed_register_file;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd1_data, rd2_data;
    logic        save = 1'b0, restore = 1'b0, cwp_wr = 1'b0, wim_wr = 1'b0;
    logic [1:0]  cwp_in = '0;
    logic [3:0]  wim_in = '0;
    logic [1:0]  cwp;
    logic [3:0]  wim;
    logic        trap_ovf, trap_unf;

    windowed_register_file #(.DATA_W(32), .NWINDOWS(4)) dut (
        .CLK(CLK), .RST(RST), .rs1(rs1), .rs2(rs2), .rd(rd), .wr_en(wr_en),
        .wr_data(wr_data), .rd1_data(rd1_data), .rd2_data(rd2_data),
        .save(save), .restore(restore), .cwp_wr(cwp_wr), .cwp_in(cwp_in),
        .wim_wr(wim_wr), .wim_in(wim_in), .cwp(cwp), .wim(wim),
        .trap_ovf(trap_ovf), .trap_unf(trap_unf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic sv, rs, cw; logic [1:0] ci; logic ww; logic [3:0] wi;
        logic we; logic [4:0] rd; logic [31:0] wd;
        logic [4:0] a1, a2; logic [31:0] e1, e2;
        logic [1:0] ecwp; logic [3:0] ewim; logic eovf, eunf;
    } vec_t;

    typedef struct packed { logic [1:0] cwp; logic [3:0] wim; logic ovf, unf; } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, want);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        @(negedge CLK);
        save = v.sv; restore = v.rs; cwp_wr = v.cw; cwp_in = v.ci;
        wim_wr = v.ww; wim_in = v.wi; wr_en = v.we; rd = v.rd; wr_data = v.wd;
        rs1 = v.a1; rs2 = v.a2;
        #1;
        chk("rd1", idx, rd1_data, v.e1);
        chk("rd2", idx, rd2_data, v.e2);
        exp_q.push_back('{v.ecwp, v.ewim, v.eovf, v.eunf});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk("cwp", idx, 32'(cwp), 32'(e.cwp));
        chk("wim", idx, 32'(wim), 32'(e.wim));
        chk("ovf", idx, 32'(trap_ovf), 32'(e.ovf));
        chk("unf", idx, 32'(trap_unf), 32'(e.unf));
    endtask

    initial begin
        //                sv rs cw ci ww wi   we rd  wd            a1  a2  e1            e2            cwp wim  ovf unf
        vecs.push_back(vec_t'{0,0,0,0, 0,4'h0, 1,0,  32'hFFFFFFFF, 0,  1,  32'h0,        32'h0,        0, 4'h2, 0,0});
        vecs.push_back(vec_t'{0,0,0,0, 0,4'h0, 1,8,  32'hA5A5A5A5, 0,  8,  32'h0,        32'h0,        0, 4'h2, 0,0});
        vecs.push_back(vec_t'{1,0,0,0, 0,4'h0, 0,0,  32'h0,        8,  1,  32'hA5A5A5A5, 32'h0,        3, 4'h2, 0,0});
        vecs.push_back(vec_t'{0,0,0,0, 0,4'h0, 0,0,  32'h0,        24, 16, 32'hA5A5A5A5, 32'h0,        3, 4'h2, 0,0});
        vecs.push_back(vec_t'{1,0,0,0, 0,4'h0, 0,0,  32'h0,        24, 8,  32'hA5A5A5A5, 32'h0,        2, 4'h2, 0,0});
        vecs.push_back(vec_t'{1,0,0,0, 0,4'h0, 1,8,  32'hDEAD,     16, 24, 32'h0,        32'h0,        2, 4'h2, 1,0});
        vecs.push_back(vec_t'{0,0,0,0, 0,4'h0, 0,0,  32'h0,        8,  1,  32'h0,        32'h0,        2, 4'h2, 0,0});
        vecs.push_back(vec_t'{1,0,0,0, 0,4'h0, 0,0,  32'h0,        0,  0,  32'h0,        32'h0,        2, 4'h2, 1,0});
        vecs.push_back(vec_t'{1,0,0,0, 0,4'h0, 0,0,  32'h0,        0,  0,  32'h0,        32'h0,        2, 4'h2, 1,0});
        vecs.push_back(vec_t'{0,0,0,0, 0,4'h0, 0,0,  32'h0,        0,  0,  32'h0,        32'h0,        2, 4'h2, 0,0});
        vecs.push_back(vec_t'{1,0,1,0, 0,4'h0, 1,16, 32'h77,       24, 16, 32'h0,        32'h0,        0, 4'h2, 0,0});
        vecs.push_back(vec_t'{0,0,1,2, 0,4'h0, 1,9,  32'h99,       16, 24, 32'h0,        32'h0,        2, 4'h2, 0,0});
        vecs.push_back(vec_t'{0,0,1,0, 0,4'h0, 0,0,  32'h0,        16, 9,  32'h77,       32'h0,        0, 4'h2, 0,0});
        vecs.push_back(vec_t'{1,0,0,0, 0,4'h0, 1,16, 32'h1234,     9,  8,  32'h99,       32'hA5A5A5A5, 3, 4'h2, 0,0});
        vecs.push_back(vec_t'{0,1,0,0, 0,4'h0, 0,0,  32'h0,        16, 24, 32'h1234,     32'hA5A5A5A5, 0, 4'h2, 0,0});
        vecs.push_back(vec_t'{0,1,0,0, 0,4'h0, 1,9,  32'hBAD,      16, 8,  32'h0,        32'hA5A5A5A5, 0, 4'h2, 0,1});
        vecs.push_back(vec_t'{0,1,0,0, 1,4'h0, 0,0,  32'h0,        9,  0,  32'h99,       32'h0,        0, 4'h0, 0,1});
        vecs.push_back(vec_t'{0,1,0,0, 0,4'h0, 0,0,  32'h0,        9,  0,  32'h99,       32'h0,        1, 4'h0, 0,0});
        vecs.push_back(vec_t'{1,1,0,0, 0,4'h0, 1,8,  32'h5555,     8,  0,  32'h0,        32'h0,        1, 4'h0, 0,0});
        vecs.push_back(vec_t'{0,0,1,0, 1,4'h8, 0,0,  32'h0,        8,  24, 32'h5555,     32'h0,        0, 4'h8, 0,0});
        vecs.push_back(vec_t'{1,0,0,0, 0,4'h0, 0,0,  32'h0,        24, 0,  32'h5555,     32'h0,        0, 4'h8, 1,0});
        vecs.push_back(vec_t'{0,0,0,0, 0,4'h0, 1,1,  32'h11,       1,  0,  32'h0,        32'h0,        0, 4'h8, 0,0});
        vecs.push_back(vec_t'{0,0,1,3, 0,4'h0, 0,0,  32'h0,        1,  8,  32'h11,       32'hA5A5A5A5, 3, 4'h8, 0,0});

        // Reset state: every logical register reads zero, cwp/wim/traps at their reset values.
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            chk("rst_rd", i, rd1_data, 32'h0);
        end
        chk("rst_cwp", 0, 32'(cwp), 32'h0);
        chk("rst_wim", 0, 32'(wim), 32'h2);
        chk("rst_ovf", 0, 32'(trap_ovf), 32'h0);
        chk("rst_unf", 0, 32'(trap_unf), 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Asynchronous reset between edges while at cwp=3 with populated registers.
        @(negedge CLK);
        save = 0; restore = 0; cwp_wr = 0; wim_wr = 0; wr_en = 0;
        rs1 = 5'd24; rs2 = 5'd1;
        #1;
        chk("pre_rst_rd1", 0, rd1_data, 32'hA5A5A5A5);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_cwp", 0, 32'(cwp), 32'h0);
        chk("mid_rst_wim", 0, 32'(wim), 32'h2);
        chk("mid_rst_rd1", 0, rd1_data, 32'h0);
        chk("mid_rst_rd2", 0, rd2_data, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        apply(100, vec_t'{1,0,0,0, 0,4'h0, 0,0, 32'h0, 24, 1, 32'h0, 32'h0, 3, 4'h2, 0,0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
